gf2m_digit_feeder: RTL and testbench

- Front-end sequencer for the digit-serial GF(2^m) multiplier (gf2m). It drives the multiplier's a, g, b, start inputs and receives its done, t_i_j outputs.
- Accepts a full operand triple (A, B, G) from a host over a valid/ready handshake and latches it.
- Pulses start, then serialises B into the multiplier DIGITAL bits per cycle, MSB digit first.
- Captures the product when the multiplier reports done and holds it on a valid/ready result port until the host takes it.

---
 rtl/gf2m_pkg.sv | 22 ++
 rtl/gf2m_digit_shreg.sv | 36 +++
 rtl/gf2m_digit_feeder.sv | 194 +++++++++++++++++++
 tb/tb_gf2m_digit_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m_pkg.sv
// Shared defaults, digit-count derivation and feeder state encoding for the GF(2^m)
// digit-serial multiplier front end.
package gf2m_pkg;

    localparam int unsigned DIGITAL_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF = 163;

    // One extra digit so the MSB digit always carries at least one pad bit.
    function automatic int unsigned ndig(input int unsigned data_width,
                                         input int unsigned digital);
        return data_width / digital + 1;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StFeed,
        StWait,
        StOut
    } feeder_state_e;

endpackage

// File: rtl/gf2m_digit_shreg.sv
// Loadable left-shift register presenting its most significant DIGITAL bits as the
// current digit; each shift moves the next digit into the top position.
module gf2m_digit_shreg #(
    parameter int unsigned DIGITAL = 4,
    parameter int unsigned WIDTH   = 164
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [WIDTH-1:0]   din,
    output logic [DIGITAL-1:0] digit
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = sr_q << DIGITAL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign digit = sr_q[WIDTH-1 -: DIGITAL];

endmodule

// File: rtl/gf2m_digit_feeder.sv
// Host-side sequencer for the digit-serial GF(2^m) multiplier: latches an operand triple,
// pulses start, streams B MSB digit first and returns the product on a valid/ready port.
// Define GF_FEEDER_TIMEOUT_EN to add the WAIT watchdog and the sticky err output.
module gf2m_digit_feeder
    import gf2m_pkg::*;
#(
    parameter int unsigned DIGITAL    = DIGITAL_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
`ifdef GF_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_g,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_g,
    output logic [DIGITAL-1:0]    mul_b,
    input  logic                  mul_done,
    input  logic [DATA_WIDTH-1:0] mul_t
`ifdef GF_FEEDER_TIMEOUT_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned NDIG = ndig(DATA_WIDTH, DIGITAL);
    localparam int unsigned BW   = NDIG * DIGITAL;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LastDig = CW'(NDIG - 1);

    feeder_state_e         state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  mul_start_q, mul_start_d;
    logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d;
    logic [DATA_WIDTH-1:0] mul_g_q, mul_g_d;
    logic [DIGITAL-1:0]    mul_b_q, mul_b_d;

    logic                  sh_load, sh_shift;
    logic [DIGITAL-1:0]    sh_digit;
    logic [BW-1:0]         b_pad;

`ifdef GF_FEEDER_TIMEOUT_EN
    localparam int unsigned WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] LastWait = WCW'(TIMEOUT - 1);
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           err_q, err_d;
`endif

    assign b_pad = BW'(in_b);

    gf2m_digit_shreg #(
        .DIGITAL (DIGITAL),
        .WIDTH   (BW)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (b_pad),
        .digit (sh_digit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        mul_a_d     = mul_a_q;
        mul_g_d     = mul_g_q;
        mul_start_d = 1'b0;
        mul_b_d     = '0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
`ifdef GF_FEEDER_TIMEOUT_EN
        wcnt_d      = wcnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    mul_a_d     = in_a;
                    mul_g_d     = in_g;
                    sh_load     = 1'b1;
                    mul_start_d = 1'b1;
                    in_ready_d  = 1'b0;
                    state_d     = StStart;
                end
            end
            // mul_b is registered, so the digit for FEED cycle k is staged one cycle early.
            StStart: begin
                mul_b_d  = sh_digit;
                sh_shift = 1'b1;
                cnt_d    = '0;
                state_d  = StFeed;
            end
            StFeed: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastDig) begin
                    state_d = StWait;
`ifdef GF_FEEDER_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end else begin
                    mul_b_d  = sh_digit;
                    sh_shift = 1'b1;
                end
            end
            StWait: begin
                if (mul_done) begin
                    res_data_d  = mul_t;
                    res_valid_d = 1'b1;
                    state_d     = StOut;
`ifdef GF_FEEDER_TIMEOUT_EN
                end else if (wcnt_q == LastWait) begin
                    err_d       = 1'b1;
                    res_data_d  = '0;
                    res_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
`endif
                end
            end
            StOut: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_g_q     <= '0;
            mul_b_q     <= '0;
`ifdef GF_FEEDER_TIMEOUT_EN
            wcnt_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_g_q     <= mul_g_d;
            mul_b_q     <= mul_b_d;
`ifdef GF_FEEDER_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_g     = mul_g_q;
    assign mul_b     = mul_b_q;
`ifdef GF_FEEDER_TIMEOUT_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_gf2m_digit_feeder.sv
// Directed bench for gf2m_digit_feeder with a behavioural digit-serial multiplier stand-in.
`timescale 1ns/1ps
module tb_gf2m_digit_feeder;

    localparam int unsigned DW = 163;
    localparam int unsigned DG = 4;
    localparam int unsigned ND = 41;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic [DW-1:0] in_g = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          mul_start;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_g;
    logic [DG-1:0] mul_b;
    logic          mul_done = 1'b0;
    logic [DW-1:0] mul_t = '0;
`ifdef GF_FEEDER_TIMEOUT_EN
    logic          err;
`endif

    int total = 0;
    int bad   = 0;

    gf2m_digit_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_g      (in_g),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_g     (mul_g),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_t     (mul_t)
`ifdef GF_FEEDER_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: gathers the streamed digits and raises done with the product.
    logic [ND*DG-1:0] mb_acc = '0;
    int               mcnt = ND;
    logic             done_en = 1'b1;

    function automatic logic [DW-1:0] gfmul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] g);
        logic [DW-1:0] p;
        p = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (p[DW-1]) p = (p << 1) ^ g;
            else         p = p << 1;
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            mcnt     = ND;
            mul_done = 1'b0;
        end else if (mul_start) begin
            mcnt     = 0;
            mul_done = 1'b0;
            mb_acc   = '0;
        end else if (mcnt < ND) begin
            mb_acc = {mb_acc[ND*DG-DG-1:0], mul_b};
            mcnt++;
            if (mcnt == ND) begin
                mul_t    = gfmul(mul_a, mb_acc[DW-1:0], mul_g);
                mul_done = done_en;
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] g);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_g     = g;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until res_valid is seen high, bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (!res_valid && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int            n;
        logic [DW-1:0] b_probe;
        logic [ND*DG-1:0] exp_pad;

        // Reset values
        tick();
        tick();
        check("rst_in_ready",  in_ready,  1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data",  res_data,  0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_b",     mul_b,     0);
        check("rst_mul_a",     mul_a,     0);
        check("rst_mul_g",     mul_g,     0);
        rst = 1'b1;
        tick();

        // 1 * 1 = 1, latency 43
        accept(1, 1, 'hC9);
        check("op1_start",     mul_start, 1);
        check("op1_start_b",   mul_b,     0);
        check("op1_in_ready",  in_ready,  0);
        check("op1_mul_a",     mul_a,     1);
        check("op1_mul_g",     mul_g,     'hC9);
        wait_result(n);
        check("op1_latency",   n,         43);
        check("op1_res",       res_data,  1);
        check("op1_hold_a",    mul_a,     1);
        release_result();
        check("op1_rel_valid", res_valid, 0);
        check("op1_rel_ready", in_ready,  1);

        // x * x^162 = x^163 -> reduces to G
        accept(2, {1'b1, 162'b0}, 'hC9);
        wait_result(n);
        check("op2_latency",   n,         43);
        check("op2_res",       res_data,  'hC9);
        release_result();

        // Digit stream: 41 digits MSB first, then stall in OUT with in_valid held high
        b_probe = {1'b1, 150'b0, 12'h123};
        exp_pad = {1'b0, b_probe};
        accept(1, b_probe, 'hC9);
        check("op3_start",     mul_start, 1);
        check("op3_start_b",   mul_b,     0);
        for (int k = 0; k < ND; k++) begin
            tick();
            check($sformatf("op3_digit%0d", k), mul_b, exp_pad[(ND-k)*DG-1 -: DG]);
            if (k == 0) check("op3_start_low", mul_start, 0);
        end
        tick();
        check("op3_wait_b",    mul_b,     0);
        tick();
        check("op3_valid",     res_valid, 1);
        check("op3_res",       res_data,  b_probe);
        in_valid = 1'b1;
        in_a     = 3;
        in_b     = 5;
        in_g     = 'hC9;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("stall_valid",    res_valid, 1);
            check("stall_data",     res_data,  b_probe);
            check("stall_in_ready", in_ready,  0);
            check("stall_start",    mul_start, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("stall_idle_valid", res_valid, 0);
        check("stall_idle_ready", in_ready,  1);
        check("stall_idle_start", mul_start, 0);
        tick();
        in_valid = 1'b0;
        check("op4_start",     mul_start, 1);
        check("op4_mul_a",     mul_a,     3);
        wait_result(n);
        check("op4_latency",   n,         43);
        check("op4_res",       res_data,  'hF);
        release_result();

        // Reset while FEED counter is 10
        accept(1, {3'b101, 160'hF0F0}, 'hC9);
        for (int c = 0; c < 11; c++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("mid_in_ready",  in_ready,  1);
        check("mid_res_valid", res_valid, 0);
        check("mid_res_data",  res_data,  0);
        check("mid_mul_start", mul_start, 0);
        check("mid_mul_b",     mul_b,     0);
        check("mid_mul_a",     mul_a,     0);
        check("mid_mul_g",     mul_g,     0);
        tick();
        rst = 1'b1;
        tick();
        accept({1'b1, 162'b0}, 2, 'hC9);
        wait_result(n);
        check("op5_latency",   n,         43);
        check("op5_res",       res_data,  'hC9);
        release_result();

`ifdef GF_FEEDER_TIMEOUT_EN
        // Watchdog: done never arrives
        done_en = 1'b0;
        accept(1, 1, 'hC9);
        wait_result(n);
        check("to_latency",    n,         42 + 64);
        check("to_err",        err,       1);
        check("to_res",        res_data,  0);
        release_result();
        check("to_err_sticky", err,       1);
        rst = 1'b0;
        #1;
        check("to_err_rst",    err,       0);
        rst = 1'b1;
        done_en = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
